dram_rd_arbiter: RTL and testbench
==================================

DRAM_RD_ARBITER -- requirements
Module: dram_rd_arbiter

Interface
REQ-001 SHALL have parameter DRAM_ADDR_WIDTH, default 18: DRAM word address width.
REQ-002 SHALL have parameter DATA_IN_DRAM_WIDTH, default 32: DRAM read word width.
REQ-003 SHALL have parameter LEN_WIDTH, default 8: burst length field width, in words.
REQ-004 SHALL have parameter RD_LATENCY, default 2 (legal 1..8): cycles from dram_rd_en_o to valid dram_rd_data_i.
REQ-005 SHALL have port clk_i, input, 1 bit: single clock; all logic on the rising edge.
REQ-006 SHALL have port general_rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port req_i, input, 3 bits: per-requester burst request; 0 = weights, 1 = signals, 2 = inputs.
REQ-008 SHALL have port req_addr_i, input, 3*DRAM_ADDR_WIDTH bits: per-requester start address; requester k occupies slice k.
REQ-009 SHALL have port req_len_i, input, 3*LEN_WIDTH bits: per-requester burst length in words.
REQ-010 SHALL have port gnt_o, output, 3 bits: one-hot grant, held for the whole burst.
REQ-011 SHALL have port done_o, output, 3 bits: one-cycle burst-complete pulse to the granted requester.
REQ-012 SHALL have port dram_rd_en_o, output, 1 bit: DRAM read strobe.
REQ-013 SHALL have port dram_rd_address_o, output, DRAM_ADDR_WIDTH bits: DRAM read address.
REQ-014 SHALL have port dram_rd_data_i, input, DATA_IN_DRAM_WIDTH bits: DRAM read data.
REQ-015 SHALL have port rd_data_o, output, DATA_IN_DRAM_WIDTH bits: returned data, registered.
REQ-016 SHALL have port rd_valid_o, output, 1 bit: rd_data_o valid.
REQ-017 SHALL have port rd_id_o, output, 2 bits: requester index owning rd_data_o.
REQ-018 SHALL have port rd_last_o, output, 1 bit: marks the final word of the burst.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-020 IDLE with any req_i bit set SHALL pick a winner round-robin, starting the search at rr_ptr (modulo 3).
REQ-021 IDLE winner SHALL latch base address and length from its slices, set gnt_o one-hot on the next cycle, and go to ISSUE.
REQ-022 ISSUE SHALL assert dram_rd_en_o for exactly len consecutive cycles, with dram_rd_address_o = base + n for n = 0..len-1.
REQ-023 Address arithmetic SHALL be modulo 2^DRAM_ADDR_WIDTH: wrap silently at the top.
REQ-024 ISSUE SHALL go to DRAIN after the last issue.
REQ-025 DRAIN SHALL hold until every issued word has returned, then go to DONE.
REQ-026 DONE SHALL last exactly 1 cycle: done_o[winner] = 1, gnt_o = 0, rr_ptr = winner+1 mod 3, then go to IDLE.
REQ-027 Minimum gap between bursts SHALL be 1 IDLE cycle.
REQ-028 The return path SHALL be a RD_LATENCY-deep shift pipeline of {valid, id, last} aligned to dram_rd_data_i.
REQ-029 rd_valid_o SHALL assert RD_LATENCY+1 cycles after the matching dram_rd_en_o, with rd_data_o registered from dram_rd_data_i.
REQ-030 rd_last_o SHALL be 1 only on the word issued at n = len-1.
REQ-031 len = 0 SHALL grant, skip ISSUE and DRAIN, and go straight to DONE (done_o pulse, no DRAM read).
REQ-032 Deasserting req_i mid-burst SHALL be ignored: the burst completes in full.
REQ-033 req_addr_i / req_len_i changes after grant SHALL be ignored.
REQ-034 dram_rd_en_o SHALL be 0 outside ISSUE; dram_rd_address_o SHALL hold its last value when idle.
REQ-035 gnt_o SHALL be one-hot or zero at all times.
REQ-036 done_o SHALL never pulse for a requester without a grant.

Reset
REQ-037 general_rst_ni low SHALL immediately force IDLE, rr_ptr = 0, and every output to 0, including pipeline contents.
REQ-038 Reset mid-burst SHALL discard outstanding returns: no rd_valid_o and no done_o after release.
REQ-039 The first arbitration after reset release SHALL occur on the first rising edge with general_rst_ni high.

Verification
REQ-040 Single burst: req_i=001, addr 0x00100, len 4, RD_LATENCY 2 -> dram_rd_en_o 4 cycles at 0x100..0x103; rd_valid_o 4 cycles with rd_id_o=0 and rd_last_o on the 4th; done_o=001 once.
REQ-041 Contention: req_i=111 held, len 2 each -> grant order 0,1,2,0; each done_o followed by 1 IDLE cycle.
REQ-042 Wrap: addr 0x3FFFE, len 4 -> addresses 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.
REQ-043 len=0 on requester 2 -> no dram_rd_en_o; done_o=100 two cycles after req_i asserts.
REQ-044 Reset asserted on 2nd issue cycle of an 8-word burst -> all outputs 0 immediately; after release with req_i=0, no rd_valid_o for 10 cycles.
REQ-045 Request drop: req_i[1] deasserted after grant, len 3 -> all 3 words returned and done_o=010 still pulses.

Source files
------------

// File: rtl/dram_rd_arbiter.sv
// Three-way round-robin burst read arbiter in front of a single DRAM read port.
// Issues one word per cycle and tags each return through a latency-matched pipeline.
module dram_rd_arbiter #(
   parameter int DRAM_ADDR_WIDTH    = 18,
   parameter int DATA_IN_DRAM_WIDTH = 32,
   parameter int LEN_WIDTH          = 8,
   parameter int RD_LATENCY         = 2
) (
   input  logic                          clk_i,
   input  logic                          general_rst_ni,
   input  logic [2:0]                    req_i,
   input  logic [3*DRAM_ADDR_WIDTH-1:0]  req_addr_i,
   input  logic [3*LEN_WIDTH-1:0]        req_len_i,
   output logic [2:0]                    gnt_o,
   output logic [2:0]                    done_o,
   output logic                          dram_rd_en_o,
   output logic [DRAM_ADDR_WIDTH-1:0]    dram_rd_address_o,
   input  logic [DATA_IN_DRAM_WIDTH-1:0] dram_rd_data_i,
   output logic [DATA_IN_DRAM_WIDTH-1:0] rd_data_o,
   output logic                          rd_valid_o,
   output logic [1:0]                    rd_id_o,
   output logic                          rd_last_o
);
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t                     state, state_next;
   logic [1:0]                 rr_ptr, winner, pick, idx;
   logic                       pick_valid;
   logic [LEN_WIDTH-1:0]       pick_len, len, cnt;
   logic [DRAM_ADDR_WIDTH-1:0] pick_addr, addr;
   logic                       issue_last, return_last;
   logic                       pipe_valid [RD_LATENCY];
   logic                       pipe_last  [RD_LATENCY];
   logic [1:0]                 pipe_id    [RD_LATENCY];

   function automatic logic [1:0] rr_index(input logic [1:0] base, input logic [1:0] off);
      logic [2:0] sum;
      sum = {1'b0, base} + {1'b0, off};
      return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
   endfunction

   // Scan the farthest offset first so the requester at rr_ptr itself has the final say.
   always_comb begin
      pick       = 2'd0;
      pick_valid = 1'b0;
      pick_len   = '0;
      pick_addr  = '0;
      idx        = 2'd0;
      for (int i = 2; i >= 0; i--) begin
         idx = rr_index(rr_ptr, 2'(i));
         if (req_i[idx]) begin
            pick       = idx;
            pick_valid = 1'b1;
            pick_len   = req_len_i[idx*LEN_WIDTH +: LEN_WIDTH];
            pick_addr  = req_addr_i[idx*DRAM_ADDR_WIDTH +: DRAM_ADDR_WIDTH];
         end
      end
   end

   assign issue_last        = (cnt == len - LEN_WIDTH'(1));
   assign return_last       = pipe_valid[RD_LATENCY-1] & pipe_last[RD_LATENCY-1];
   assign dram_rd_address_o = addr;

   always_ff @(posedge clk_i or negedge general_rst_ni) begin
      if (!general_rst_ni) state <= IDLE;
      else                 state <= state_next;
   end

   always_comb begin
      state_next   = state;
      dram_rd_en_o = 1'b0;
      case (state)
         IDLE:    if (pick_valid) state_next = (pick_len == '0) ? DONE : ISSUE;
         ISSUE: begin
            dram_rd_en_o = 1'b1;
            if (issue_last) state_next = DRAIN;
         end
         DRAIN:   if (return_last) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Burst bookkeeping; the address stops on the last issued word so it holds when idle.
   always_ff @(posedge clk_i or negedge general_rst_ni) begin
      if (!general_rst_ni) begin
         rr_ptr <= 2'd0;
         winner <= 2'd0;
         len    <= '0;
         cnt    <= '0;
         addr   <= '0;
         gnt_o  <= 3'b000;
         done_o <= 3'b000;
      end else begin
         done_o <= 3'b000;
         case (state)
            IDLE: if (pick_valid) begin
               winner <= pick;
               len    <= pick_len;
               addr   <= pick_addr;
               cnt    <= '0;
               gnt_o  <= 3'b001 << pick;
            end
            ISSUE: if (!issue_last) begin
               cnt  <= cnt + LEN_WIDTH'(1);
               addr <= addr + DRAM_ADDR_WIDTH'(1);
            end
            DONE: begin
               gnt_o  <= 3'b000;
               done_o <= 3'b001 << winner;
               rr_ptr <= rr_index(winner, 2'd1);
            end
            default: ;
         endcase
      end
   end

   // Tag pipeline travels alongside the DRAM so each word arrives with its owner and last flag.
   always_ff @(posedge clk_i or negedge general_rst_ni) begin
      if (!general_rst_ni) begin
         for (int i = 0; i < RD_LATENCY; i++) begin
            pipe_valid[i] <= 1'b0;
            pipe_last[i]  <= 1'b0;
            pipe_id[i]    <= 2'd0;
         end
         rd_valid_o <= 1'b0;
         rd_data_o  <= '0;
         rd_id_o    <= 2'd0;
         rd_last_o  <= 1'b0;
      end else begin
         pipe_valid[0] <= dram_rd_en_o;
         pipe_last[0]  <= dram_rd_en_o & issue_last;
         pipe_id[0]    <= dram_rd_en_o ? winner : 2'd0;
         for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_valid[i] <= pipe_valid[i-1];
            pipe_last[i]  <= pipe_last[i-1];
            pipe_id[i]    <= pipe_id[i-1];
         end
         rd_valid_o <= pipe_valid[RD_LATENCY-1];
         rd_last_o  <= pipe_last[RD_LATENCY-1];
         rd_id_o    <= pipe_id[RD_LATENCY-1];
         if (pipe_valid[RD_LATENCY-1]) rd_data_o <= dram_rd_data_i;
      end
   end
endmodule

// File: tb/tb_dram_rd_arbiter.sv
// Bench for dram_rd_arbiter: a transaction-level model predicts every grant, issue,
// return and done pulse of each scenario, and the logged DUT activity is compared to it.
module tb_dram_rd_arbiter;
   localparam int AW  = 18;
   localparam int DW  = 32;
   localparam int LW  = 8;
   localparam int LAT = 2;

   typedef struct packed {
      logic [31:0] cyc;
      logic [31:0] a;
      logic [31:0] b;
   } ev_t;

   logic            clk_i          = 1'b0;
   logic            general_rst_ni = 1'b1;
   logic [2:0]      req_i          = '0;
   logic [3*AW-1:0] req_addr_i     = '0;
   logic [3*LW-1:0] req_len_i      = '0;
   logic [DW-1:0]   dram_rd_data_i = '0;
   logic [2:0]      gnt_o, done_o;
   logic            dram_rd_en_o, rd_valid_o, rd_last_o;
   logic [AW-1:0]   dram_rd_address_o;
   logic [DW-1:0]   rd_data_o;
   logic [1:0]      rd_id_o;

   int          cyc        = 0;
   int          passCount  = 0;
   int          checkCount = 0;
   int          rrModel    = 0;
   logic [2:0]  prevGnt    = '0;
   logic [31:0] ringData  [16];
   bit          ringValid [16];
   ev_t         actEn[$], actRd[$], actGnt[$], actDone[$];

   dram_rd_arbiter #(
      .DRAM_ADDR_WIDTH(AW), .DATA_IN_DRAM_WIDTH(DW), .LEN_WIDTH(LW), .RD_LATENCY(LAT)
   ) dut (
      .clk_i(clk_i), .general_rst_ni(general_rst_ni), .req_i(req_i),
      .req_addr_i(req_addr_i), .req_len_i(req_len_i), .gnt_o(gnt_o), .done_o(done_o),
      .dram_rd_en_o(dram_rd_en_o), .dram_rd_address_o(dram_rd_address_o),
      .dram_rd_data_i(dram_rd_data_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
      .rd_id_o(rd_id_o), .rd_last_o(rd_last_o)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   function automatic logic [31:0] memWord(input logic [AW-1:0] a);
      return (32'(a) * 32'h9E3779B1) ^ 32'hC0DE0000;
   endfunction

   function automatic logic [95:0] outputsNow();
      return 96'({gnt_o, done_o, dram_rd_en_o, dram_rd_address_o, rd_valid_o,
                  rd_data_o, rd_id_o, rd_last_o});
   endfunction

   task automatic checkOutput(input string tag, input logic [95:0] observed,
                              input logic [95:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
         $error("[TB] %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Mid-cycle monitor: logs DUT events, checks grant/done invariants and plays the DRAM.
   always @(negedge clk_i) begin
      int rs, ws;
      if (general_rst_ni) begin
         checkOutput("gntOneHot", 96'($onehot0(gnt_o)), 96'd1);
         checkOutput("doneNeedsGrant", 96'(done_o & ~prevGnt), 96'd0);
         if (dram_rd_en_o) actEn.push_back('{32'(cyc), 32'(dram_rd_address_o), 32'd0});
         if (rd_valid_o) actRd.push_back('{32'(cyc), rd_data_o, 32'({rd_id_o, rd_last_o})});
         if (gnt_o != 3'b000 && gnt_o != prevGnt) actGnt.push_back('{32'(cyc), 32'(gnt_o), 32'd0});
         if (done_o != 3'b000) actDone.push_back('{32'(cyc), 32'(done_o), 32'd0});
      end
      prevGnt = gnt_o;
      rs = (cyc - LAT) & 15;
      ws = cyc & 15;
      dram_rd_data_i = ringValid[rs] ? ringData[rs] : $urandom;
      ringValid[ws]  = general_rst_ni && dram_rd_en_o;
      ringData[ws]   = memWord(dram_rd_address_o);
   end

   task automatic compareLogs(input string name, input ev_t act[$], input ev_t exp[$]);
      checkOutput({name, "Count"}, 96'(act.size()), 96'(exp.size()));
      for (int i = 0; i < exp.size() && i < act.size(); i++)
         checkOutput($sformatf("%s[%0d]", name, i), act[i], exp[i]);
   endtask

   // Holds the request pattern for nb bursts, predicting each burst from the round-robin rule:
   // grant one cycle after the request is seen, len issues, returns LAT+1 after each issue,
   // done one cycle after the last return, next grant one idle cycle later.
   task automatic applyStimulus(input logic [2:0] req, input logic [3*AW-1:0] addrs,
                                input logic [3*LW-1:0] lens, input int nb, input bit dropReq);
      ev_t           expEn[$], expRd[$], expGnt[$], expDone[$];
      int            g, d, k, ln, rr, waited;
      logic [AW-1:0] base, a;
      @(negedge clk_i); #1;
      actEn.delete(); actRd.delete(); actGnt.delete(); actDone.delete();
      req_addr_i = addrs;
      req_len_i  = lens;
      req_i      = req;
      g  = cyc + 1;
      rr = rrModel;
      for (int b = 0; b < nb; b++) begin
         k = -1;
         for (int i = 0; i < 3; i++)
            if (k < 0 && req[(rr + i) % 3]) k = (rr + i) % 3;
         ln   = int'(lens[k*LW +: LW]);
         base = addrs[k*AW +: AW];
         expGnt.push_back('{32'(g), 32'(1 << k), 32'd0});
         for (int n = 0; n < ln; n++) begin
            a = base + AW'(n);
            expEn.push_back('{32'(g + n), 32'(a), 32'd0});
            expRd.push_back('{32'(g + n + LAT + 1), memWord(a), 32'(k * 2 + ((n == ln - 1) ? 1 : 0))});
         end
         d = (ln == 0) ? g + 1 : g + ln + LAT + 1;
         expDone.push_back('{32'(d), 32'(1 << k), 32'd0});
         rr = (k + 1) % 3;
         g  = d + 1;
      end
      rrModel = rr;
      waited = 0;
      while (actDone.size() < nb && waited < 400) begin
         @(negedge clk_i); #1;
         waited++;
         if (dropReq && actGnt.size() > 0) req_i = 3'b000;
         if (actDone.size() >= nb) req_i = 3'b000;
      end
      checkOutput("burstsCompleted", 96'(actDone.size()), 96'(nb));
      req_i = 3'b000;
      repeat (LAT + 4) begin @(negedge clk_i); #1; end
      compareLogs("grant", actGnt, expGnt);
      compareLogs("issue", actEn, expEn);
      compareLogs("return", actRd, expRd);
      compareLogs("done", actDone, expDone);
   endtask

   initial begin
      logic [3*AW-1:0] ra;
      logic [3*LW-1:0] rl;
      int              waited;
      #2 general_rst_ni = 1'b0;
      #1 checkOutput("resetOutputs", outputsNow(), 96'd0);
      repeat (2) @(negedge clk_i);
      general_rst_ni = 1'b1;
      rrModel = 0;

      applyStimulus(3'b111, {18'h00300, 18'h00200, 18'h00100}, {8'd2, 8'd2, 8'd2}, 4, 1'b0);
      applyStimulus(3'b001, {36'h0, 18'h00100}, {16'h0, 8'd4}, 1, 1'b0);
      applyStimulus(3'b001, {36'h0, 18'h3FFFE}, {16'h0, 8'd4}, 1, 1'b0);
      applyStimulus(3'b100, {18'h00abc, 36'h0}, {8'd0, 8'd5, 8'd5}, 1, 1'b0);
      applyStimulus(3'b010, {18'h0, 18'h02000, 18'h0}, {8'd0, 8'd3, 8'd0}, 1, 1'b1);

      for (int s = 0; s < 10; s++) begin
         for (int k = 0; k < 3; k++) begin
            if ($urandom_range(0, 3) == 0) ra[k*AW +: AW] = 18'h3FFFF - AW'($urandom_range(0, 3));
            else                           ra[k*AW +: AW] = AW'($urandom);
            rl[k*LW +: LW] = LW'($urandom_range(0, 5));
         end
         applyStimulus(3'($urandom_range(1, 7)), ra, rl, $urandom_range(1, 4), 1'b0);
      end

      @(negedge clk_i); #1;
      actGnt.delete();
      req_addr_i = {18'h0, 18'h01230, 18'h0};
      req_len_i  = {8'd0, 8'd8, 8'd0};
      req_i      = 3'b010;
      waited = 0;
      while (actGnt.size() == 0 && waited < 20) begin @(negedge clk_i); #1; waited++; end
      checkOutput("resetBurstGranted", 96'(actGnt.size()), 96'd1);
      @(negedge clk_i); #1;
      checkOutput("secondIssue", 96'({dram_rd_en_o, dram_rd_address_o}), 96'({1'b1, 18'h01231}));
      general_rst_ni = 1'b0;
      req_i = 3'b000;
      #1 checkOutput("midBurstResetOutputs", outputsNow(), 96'd0);
      repeat (2) @(negedge clk_i);
      #1 general_rst_ni = 1'b1;
      actEn.delete(); actRd.delete(); actDone.delete();
      repeat (10) begin @(negedge clk_i); #1; end
      checkOutput("noReturnAfterReset", 96'(actRd.size()), 96'd0);
      checkOutput("noDoneAfterReset", 96'(actDone.size()), 96'd0);
      checkOutput("noIssueAfterReset", 96'(actEn.size()), 96'd0);
      rrModel = 0;
      applyStimulus(3'b111, {18'h00030, 18'h00020, 18'h00010}, {8'd1, 8'd1, 8'd1}, 3, 1'b0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
